// File: rtl/gfx_line_if.sv
// Pixel stream from the line rasterizer to the framebuffer writer.
interface gfx_line_if #(
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9,
    parameter int PIXEL_BITS = 12
);
    logic [X_BITS-1:0]     gfx_x;
    logic [Y_BITS-1:0]     gfx_y;
    logic [PIXEL_BITS-1:0] gfx_color;
    logic                  gfx_valid;
    logic                  gfx_ready;
    logic                  gfx_last;

    modport master (
        output gfx_x, gfx_y, gfx_color, gfx_valid, gfx_last,
        input  gfx_ready
    );

    modport slave (
        input  gfx_x, gfx_y, gfx_color, gfx_valid, gfx_last,
        output gfx_ready
    );
endinterface

// File: rtl/gfx_line.sv
// Bresenham line rasterizer: walks all octants, clips off-screen pixels,
// emits one framebuffer pixel per cycle and pulses done at the end.
module gfx_line #(
    parameter int  H_VISIBLE  = 640,
    parameter int  V_VISIBLE  = 480,
    parameter int  PIXEL_BITS = 12,
    localparam int FB_X_BITS  = $clog2(H_VISIBLE),
    localparam int FB_Y_BITS  = $clog2(V_VISIBLE),
    localparam int ERR_BITS   = ((FB_X_BITS > FB_Y_BITS) ? FB_X_BITS : FB_Y_BITS) + 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FB_X_BITS-1:0]  x0,
    input  logic [FB_X_BITS-1:0]  x1,
    input  logic [FB_Y_BITS-1:0]  y0,
    input  logic [FB_Y_BITS-1:0]  y1,
    input  logic [PIXEL_BITS-1:0] color,
    output logic                  busy,
    output logic                  done,
    gfx_line_if.master            pix
);

    localparam logic [FB_X_BITS:0] H_LIM = (FB_X_BITS+1)'(H_VISIBLE);
    localparam logic [FB_Y_BITS:0] V_LIM = (FB_Y_BITS+1)'(V_VISIBLE);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAW} state_t;

    state_t state_q, state_n;

    // latched command
    logic [FB_X_BITS-1:0]  x0_q, x1_q;
    logic [FB_Y_BITS-1:0]  y0_q, y1_q;
    logic [PIXEL_BITS-1:0] color_q;

    // walker state (the pixel after the one presented)
    logic [FB_X_BITS-1:0]       cur_x_q;
    logic [FB_Y_BITS-1:0]       cur_y_q;
    logic signed [ERR_BITS-1:0] err_q, dx_q, dy_q;
    logic                       sx_neg_q, sy_neg_q;

    // presented pixel register
    logic                  out_ok_q, out_end_q;
    logic [FB_X_BITS-1:0]  gx_q;
    logic [FB_Y_BITS-1:0]  gy_q;
    logic [PIXEL_BITS-1:0] gc_q;
    logic                  gv_q, gl_q;
    logic                  done_q;

    // combinational helpers
    logic signed [ERR_BITS-1:0] x0_s, x1_s, y0_s, y1_s;
    logic signed [ERR_BITS-1:0] dx_init, dy_init, err_n;
    logic signed [ERR_BITS:0]   e2, dx_w, dy_w;
    logic                       step_x, step_y;
    logic                       cur_vis, cur_end;
    logic                       consumed, advance, finish;

    assign x0_s = ERR_BITS'(x0_q);
    assign x1_s = ERR_BITS'(x1_q);
    assign y0_s = ERR_BITS'(y0_q);
    assign y1_s = ERR_BITS'(y1_q);

    assign dx_init = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
    assign dy_init = (y1_s >= y0_s) ? (y0_s - y1_s) : (y1_s - y0_s);

    assign e2     = {err_q, 1'b0};
    assign dx_w   = {dx_q[ERR_BITS-1], dx_q};
    assign dy_w   = {dy_q[ERR_BITS-1], dy_q};
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);

    assign cur_vis = ({1'b0, cur_x_q} < H_LIM) && ({1'b0, cur_y_q} < V_LIM);
    assign cur_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);

    // A clipped pixel sits in the output register with valid low and is
    // retired unconditionally; a visible one waits for ready.
    assign consumed = out_ok_q && (!gv_q || pix.gfx_ready);
    assign advance  = !out_ok_q || consumed;
    assign finish   = (state_q == S_DRAW) && consumed && out_end_q;

    // Both error updates use the same old e2.
    always_comb begin
        err_n = err_q;
        if (step_x) err_n = err_n + dy_q;
        if (step_y) err_n = err_n + dx_q;
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (start) state_n = S_INIT;
            S_INIT:  state_n = S_DRAW;
            S_DRAW:  if (finish) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_n;
    end

    // Command latch, Bresenham walker and output register.
    // The walker runs one pixel ahead of the output register so a new pixel
    // can be loaded on the same edge the presented one is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            err_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            out_ok_q  <= 1'b0;
            out_end_q <= 1'b0;
            gx_q      <= '0;
            gy_q      <= '0;
            gc_q      <= '0;
            gv_q      <= 1'b0;
            gl_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= finish;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x0_q    <= x0;
                        x1_q    <= x1;
                        y0_q    <= y0;
                        y1_q    <= y1;
                        color_q <= color;
                    end
                end
                S_INIT: begin
                    dx_q      <= dx_init;
                    dy_q      <= dy_init;
                    sx_neg_q  <= !(x0_q < x1_q);
                    sy_neg_q  <= !(y0_q < y1_q);
                    err_q     <= dx_init + dy_init;
                    cur_x_q   <= x0_q;
                    cur_y_q   <= y0_q;
                    out_ok_q  <= 1'b0;
                    out_end_q <= 1'b0;
                end
                S_DRAW: begin
                    if (advance) begin
                        if (finish) begin
                            out_ok_q  <= 1'b0;
                            out_end_q <= 1'b0;
                            gv_q      <= 1'b0;
                            gl_q      <= 1'b0;
                        end else begin
                            gx_q      <= cur_x_q;
                            gy_q      <= cur_y_q;
                            gc_q      <= color_q;
                            gv_q      <= cur_vis;
                            gl_q      <= cur_end && cur_vis;
                            out_ok_q  <= 1'b1;
                            out_end_q <= cur_end;
                            if (!cur_end) begin
                                if (step_x)
                                    cur_x_q <= sx_neg_q ? cur_x_q - FB_X_BITS'(1)
                                                        : cur_x_q + FB_X_BITS'(1);
                                if (step_y)
                                    cur_y_q <= sy_neg_q ? cur_y_q - FB_Y_BITS'(1)
                                                        : cur_y_q + FB_Y_BITS'(1);
                                err_q <= err_n;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign pix.gfx_x     = gx_q;
    assign pix.gfx_y     = gy_q;
    assign pix.gfx_color = gc_q;
    assign pix.gfx_valid = gv_q;
    assign pix.gfx_last  = gl_q;

endmodule

// File: tb/tb_gfx_line.sv
// Directed bench for gfx_line: table of line commands with expected pixel
// sequences, plus hand-written busy/chain/reset sequences.
module tb_gfx_line;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    logic [11:0] color;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    gfx_line_if #(.X_BITS(10), .Y_BITS(9), .PIXEL_BITS(12)) pix ();

    gfx_line #(.H_VISIBLE(640), .V_VISIBLE(480), .PIXEL_BITS(12)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x0    (x0),
        .x1    (x1),
        .y0    (y0),
        .y1    (y1),
        .color (color),
        .busy  (busy),
        .done  (done),
        .pix   (pix)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               x0, y0, x1, y1, color;
        bit               bp;
        int               n;
        logic [0:9][9:0]  ex;
        logic [0:9][9:0]  ey;
        bit               has_last;
        int               exp_done;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [0:9][9:0] px(input int a0, a1, a2, a3, a4,
                                           a5, a6, a7, a8, a9);
        return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 10'(a4),
                10'(a5), 10'(a6), 10'(a7), 10'(a8), 10'(a9)};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int ax0, ay0, ax1, ay1, acol,
                           input bit abp, input int an, input bit alast,
                           input int adone,
                           input logic [0:9][9:0] aex, input logic [0:9][9:0] aey);
        tbl[i].x0 = ax0; tbl[i].y0 = ay0; tbl[i].x1 = ax1; tbl[i].y1 = ay1;
        tbl[i].color = acol; tbl[i].bp = abp; tbl[i].n = an;
        tbl[i].has_last = alast; tbl[i].exp_done = adone;
        tbl[i].ex = aex; tbl[i].ey = aey;
    endtask

    // mode 0: plain run; 1: start with other endpoints mid-line;
    // 2: assert reset after two beats have been accepted.
    task automatic run_line(input int idx, input int mode, input bit linger);
        vec_t        e;
        int          cyc, nb, busyc;
        bit          seen_done, pv, pr, aborted;
        logic [32:0] prev;
        e = tbl[idx];
        x0 = 10'(e.x0); y0 = 9'(e.y0); x1 = 10'(e.x1); y1 = 9'(e.y1);
        color = 12'(e.color);
        start = 1'b1;
        cyc = 0; nb = 0; busyc = 0; seen_done = 0; pv = 0; pr = 0; aborted = 0;
        prev = '0;
        while (!seen_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                chk("busy_after_start", busy, 1);
                chk("valid_in_init", pix.gfx_valid, 0);
            end
            if (mode == 1 && cyc == 4) begin
                x0 = 10'd100; y0 = 9'd100; x1 = 10'd101; y1 = 9'd101;
                color = 12'h555; start = 1'b1;
            end
            if (mode == 1 && cyc == 5) start = 1'b0;
            if (pv && !pr)
                chk("stall_hold", {pix.gfx_x, pix.gfx_y, pix.gfx_color,
                                   pix.gfx_last, pix.gfx_valid}, prev);
            if (done) begin
                seen_done = 1;
                chk("busy_at_done", busy, 0);
                if (e.exp_done != 0) begin
                    chk("done_cycle", cyc, e.exp_done);
                    chk("busy_cycles", busyc, e.exp_done - 1);
                end
            end else begin
                if (busy) busyc++;
                if (mode == 2 && nb == 2) begin
                    reset = 1'b1;
                    #1;
                    chk("rst_mid_busy", busy, 0);
                    chk("rst_mid_valid", pix.gfx_valid, 0);
                    chk("rst_mid_last", pix.gfx_last, 0);
                    chk("rst_mid_xy", {pix.gfx_x, pix.gfx_y}, 0);
                    chk("rst_mid_color", pix.gfx_color, 0);
                    @(negedge clk);
                    reset = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        chk("rst_no_done", done, 0);
                        chk("rst_stays_idle", busy, 0);
                    end
                    aborted = 1;
                    break;
                end
                pix.gfx_ready = e.bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pix.gfx_valid && pix.gfx_ready) begin
                    if (nb < e.n) begin
                        chk("beat_x", pix.gfx_x, e.ex[nb]);
                        chk("beat_y", pix.gfx_y, e.ey[nb]);
                    end else begin
                        chk("extra_beat", nb, e.n);
                    end
                    chk("beat_color", pix.gfx_color, e.color);
                    chk("beat_last", pix.gfx_last, (e.has_last && nb == e.n - 1) ? 1 : 0);
                    nb++;
                end
                pv = pix.gfx_valid;
                pr = pix.gfx_ready;
                prev = {pix.gfx_x, pix.gfx_y, pix.gfx_color, pix.gfx_last, pix.gfx_valid};
            end
        end
        if (!aborted) begin
            if (!seen_done) chk("done_timeout", 0, 1);
            chk("beat_count", nb, e.n);
            if (linger) begin
                @(negedge clk);
                chk("done_one_cycle", done, 0);
                chk("idle_after_done", busy, 0);
                chk("valid_after_done", pix.gfx_valid, 0);
            end
        end
    endtask

    initial begin
        //       idx x0   y0   x1   y1  color  bp  n last done
        set_vec(0, 10,  20,  10,  20, 'hABC, 0, 1, 1, 4,
                px(10,0,0,0,0,0,0,0,0,0), px(20,0,0,0,0,0,0,0,0,0));
        set_vec(1, 0,   0,   3,   0,  'h123, 0, 4, 1, 7,
                px(0,1,2,3,0,0,0,0,0,0), px(0,0,0,0,0,0,0,0,0,0));
        set_vec(2, 5,   5,   2,   2,  'h0F0, 0, 4, 1, 7,
                px(5,4,3,2,0,0,0,0,0,0), px(5,4,3,2,0,0,0,0,0,0));
        set_vec(3, 0,   0,   1,   3,  'h00F, 0, 4, 1, 7,
                px(0,0,1,1,0,0,0,0,0,0), px(0,1,2,3,0,0,0,0,0,0));
        set_vec(4, 0,   0,   7,   3,  'h456, 0, 8, 1, 11,
                px(0,1,2,3,4,5,6,7,0,0), px(0,0,1,1,2,2,3,3,0,0));
        set_vec(5, 0,   0,   7,   3,  'h456, 1, 8, 1, 0,
                px(0,1,2,3,4,5,6,7,0,0), px(0,0,1,1,2,2,3,3,0,0));
        set_vec(6, 638, 0,   641, 0,  'hF00, 0, 2, 0, 7,
                px(638,639,0,0,0,0,0,0,0,0), px(0,0,0,0,0,0,0,0,0,0));
        set_vec(7, 3,   478, 3,   481,'h789, 0, 2, 0, 7,
                px(3,3,0,0,0,0,0,0,0,0), px(478,479,0,0,0,0,0,0,0,0));
        set_vec(8, 2,   3,   0,   0,  'hFFF, 0, 4, 1, 7,
                px(2,1,1,0,0,0,0,0,0,0), px(3,2,1,0,0,0,0,0,0,0));
        set_vec(9, 0,   0,   9,   0,  'h321, 0, 10, 1, 13,
                px(0,1,2,3,4,5,6,7,8,9), px(0,0,0,0,0,0,0,0,0,0));

        reset = 1'b1; start = 1'b0; pix.gfx_ready = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", pix.gfx_valid, 0);
        chk("rst_last", pix.gfx_last, 0);
        chk("rst_x", pix.gfx_x, 0);
        chk("rst_y", pix.gfx_y, 0);
        chk("rst_color", pix.gfx_color, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_line(i, 0, 1);

        // new command mid-line must be ignored
        run_line(1, 1, 1);

        // start in the done cycle is accepted
        run_line(0, 0, 0);
        run_line(2, 0, 1);

        // reset mid-line, then a clean redraw
        run_line(9, 2, 0);
        run_line(9, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
